// File: rtl/final_pwm.sv
// final_pwm: three-term sum, clamp to [0, 2**PWM_BITS], frame-locked PWM.
// Parameter PWM_BITS (4..15): frame length PERIOD = 2**PWM_BITS clocks.
// Ports:
//   clk, rst_n (async, active low), en (frame counter run enable)
//   A (unsigned), B/Bsgn, C/Csgn (sign-magnitude) : duty terms
//   step : one-clock advance request, one per completed frame
//   pwm  : registered PWM output
//   duty : duty value applied to the current frame
//   sat_cnt : saturating clamp-event count (only with ANSPWM_SATCNT_EN)
// Optional feature macro: ANSPWM_SATCNT_EN
module final_pwm #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [15:0]         A,
   input  logic [15:0]         B,
   input  logic                Bsgn,
   input  logic [15:0]         C,
   input  logic                Csgn,
   output logic                step,
   output logic                pwm,
   output logic [PWM_BITS:0]   duty
`ifdef ANSPWM_SATCNT_EN
   ,
   output logic [7:0]          sat_cnt
`endif
);

   localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS:0]   PERIOD_V = {1'b1, {PWM_BITS{1'b0}}};
   localparam logic signed [18:0]  PERIOD_S = 19'(PERIOD_V);

   logic signed [18:0]  sum_q, sum_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS:0]   duty_q, duty_d;
   logic                step_q, step_d;
   logic                pwm_q, pwm_d;

   logic signed [18:0]  a_x, b_x, c_x;
   logic [PWM_BITS:0]   clamp_val;
   logic                frame_end;

`ifdef ANSPWM_SATCNT_EN
   logic [7:0] sat_q, sat_d;
   logic       clamp_hit;
`endif

   always_comb begin
      // Sign-magnitude terms widened to 19 bits: worst case
      // 3 * 65535 fits, so the sum never overflows.
      a_x = {3'b000, A};
      b_x = Bsgn ? -{3'b000, B} : {3'b000, B};
      c_x = Csgn ? -{3'b000, C} : {3'b000, C};
      sum_d = a_x + b_x + c_x;

      if (sum_q[18]) begin
         clamp_val = '0;
      end else if (sum_q > PERIOD_S) begin
         clamp_val = PERIOD_V;
      end else begin
         clamp_val = sum_q[PWM_BITS:0];
      end

      frame_end = en && (cnt_q == CNT_MAX);

      cnt_d  = en ? cnt_q + PWM_BITS'(1) : cnt_q;
      duty_d = frame_end ? clamp_val : duty_q;
      step_d = frame_end;
      // Compare against the duty of the running frame; the
      // boundary edge still uses the old duty for cnt==MAX.
      pwm_d  = en && ({1'b0, cnt_q} < duty_q);
   end

`ifdef ANSPWM_SATCNT_EN
   assign clamp_hit = sum_q[18] || (sum_q > PERIOD_S);

   always_comb begin
      sat_d = sat_q;
      if (frame_end && clamp_hit && (sat_q != 8'hFF)) begin
         sat_d = sat_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q <= '0;
      end else begin
         sat_q <= sat_d;
      end
   end

   assign sat_cnt = sat_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cnt_q  <= '0;
         duty_q <= '0;
         step_q <= 1'b0;
         pwm_q  <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         step_q <= step_d;
         pwm_q  <= pwm_d;
      end
   end

   assign step = step_q;
   assign pwm  = pwm_q;
   assign duty = duty_q;

endmodule

// File: tb/tb_final_pwm.sv
// tb_final_pwm: directed table-driven bench for final_pwm (PWM_BITS=8).
// Frame-level checks of duty, pwm pattern, step period, en and reset.
module tb_final_pwm;

   logic        clk = 1'b0;
   logic        rst_n, en;
   logic [15:0] A, B, C;
   logic        Bsgn, Csgn;
   logic        step, pwm;
   logic [8:0]  duty;
`ifdef ANSPWM_SATCNT_EN
   logic [7:0]  sat_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   final_pwm #(.PWM_BITS(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .A(A),
      .B(B),
      .Bsgn(Bsgn),
      .C(C),
      .Csgn(Csgn),
      .step(step),
      .pwm(pwm),
      .duty(duty)
`ifdef ANSPWM_SATCNT_EN
      ,
      .sat_cnt(sat_cnt)
`endif
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bs;
      logic [15:0] c;
      logic        cs;
      int          exp_duty;
      int          clamped;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [15:0] a, input logic [15:0] b,
                         input logic bs, input logic [15:0] c,
                         input logic cs);
      A = a; B = b; Bsgn = bs; C = c; Csgn = cs;
   endtask

   // Advance negedge by negedge until step is seen, within a bound.
   task automatic wait_step(input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!step && n < bound);
      chk("step_seen", int'(step), 1);
   endtask

   // Sample one full frame starting right after a boundary.
   // Sample i reflects the compare done while cnt == i.
   task automatic run_frame(input int chg_at, input logic [15:0] new_a,
                            input int exp_high, output int highs,
                            output int steps, output int pat_err);
      highs = 0; steps = 0; pat_err = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (pwm) highs++;
         if (step) steps++;
         if (pwm !== (i < exp_high)) pat_err++;
         if (i == chg_at) A = new_a;
      end
   endtask

   initial begin
      int n, highs, steps, perr, sat0;
      vt[0]  = '{16'd100,   16'd20,    1'b1, 16'd5,     1'b0, 85,  0};
      vt[1]  = '{16'd10,    16'd50,    1'b1, 16'd0,     1'b0, 0,   1};
      vt[2]  = '{16'd300,   16'd0,     1'b0, 16'd0,     1'b0, 256, 1};
      vt[3]  = '{16'd256,   16'd0,     1'b0, 16'd0,     1'b0, 256, 0};
      vt[4]  = '{16'd0,     16'd0,     1'b0, 16'd0,     1'b0, 0,   0};
      vt[5]  = '{16'd1,     16'd0,     1'b0, 16'd0,     1'b0, 1,   0};
      vt[6]  = '{16'd255,   16'd0,     1'b0, 16'd0,     1'b0, 255, 0};
      vt[7]  = '{16'hFFFF,  16'hFFFF,  1'b0, 16'hFFFF,  1'b0, 256, 1};
      vt[8]  = '{16'd0,     16'hFFFF,  1'b1, 16'hFFFF,  1'b1, 0,   1};
      vt[9]  = '{16'd200,   16'd100,   1'b1, 16'd57,    1'b0, 157, 0};
      vt[10] = '{16'd257,   16'd0,     1'b0, 16'd0,     1'b0, 256, 1};

      rst_n = 1'b0; en = 1'b0;
      set_in(16'd0, 16'd0, 1'b0, 16'd0, 1'b0);
      @(negedge clk);
      chk("rst_duty", int'(duty), 0);
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_step", int'(step), 0);
`ifdef ANSPWM_SATCNT_EN
      chk("rst_sat", int'(sat_cnt), 0);
`endif
      rst_n = 1'b1; en = 1'b1;

      foreach (vt[k]) begin
         set_in(vt[k].a, vt[k].b, vt[k].bs, vt[k].c, vt[k].cs);
         wait_step(600, n);
         wait_step(300, n);
         chk($sformatf("v%0d_period", k), n, 256);
         chk($sformatf("v%0d_duty", k), int'(duty), vt[k].exp_duty);
`ifdef ANSPWM_SATCNT_EN
         sat0 = int'(sat_cnt);
`endif
         run_frame(-1, 16'd0, vt[k].exp_duty, highs, steps, perr);
         chk($sformatf("v%0d_high", k), highs, vt[k].exp_duty);
         chk($sformatf("v%0d_pattern", k), perr, 0);
         chk($sformatf("v%0d_steps", k), steps, 1);
         chk($sformatf("v%0d_step_end", k), int'(step), 1);
`ifdef ANSPWM_SATCNT_EN
         chk($sformatf("v%0d_sat_inc", k), int'(sat_cnt) - sat0,
             vt[k].clamped);
`endif
      end

      // Mid-frame input change must not disturb the running frame.
      set_in(16'd40, 16'd0, 1'b0, 16'd0, 1'b0);
      wait_step(600, n);
      wait_step(300, n);
      chk("mid_duty_old", int'(duty), 40);
      run_frame(29, 16'd200, 40, highs, steps, perr);
      chk("mid_high_old", highs, 40);
      chk("mid_pattern_old", perr, 0);
      chk("mid_duty_new", int'(duty), 200);
      run_frame(-1, 16'd0, 200, highs, steps, perr);
      chk("mid_high_new", highs, 200);
      chk("mid_pattern_new", perr, 0);

      // Enable drop at cnt=77 for 10 clocks, duty 100.
      A = 16'd100;
      wait_step(300, n);
      chk("en_duty", int'(duty), 100);
      highs = 0;
      for (int i = 0; i < 77; i++) begin
         @(negedge clk);
         if (pwm) highs++;
      end
      en = 1'b0;
      steps = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (pwm || step) steps++;
      end
      chk("en_off_quiet", steps, 0);
      chk("en_off_duty", int'(duty), 100);
      en = 1'b1;
      // Resume edge moves 77->78; the cnt=255 edge is 178 edges
      // later and step is seen on the negedge after it.
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (pwm) highs++;
      end while (!step && n < 400);
      chk("en_resume_step", n, 179);
      chk("en_frame_high", highs, 100);

      // Asynchronous reset between edges, mid-frame with pwm high.
      repeat (40) @(negedge clk);
      chk("pre_rst_pwm", int'(pwm), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pwm", int'(pwm), 0);
      chk("async_rst_duty", int'(duty), 0);
      chk("async_rst_step", int'(step), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(-1, 16'd0, 0, highs, steps, perr);
      chk("post_rst_high", highs, 0);
      chk("post_rst_steps", steps, 1);
      chk("post_rst_step_end", int'(step), 1);
      chk("post_rst_duty", int'(duty), 100);

`ifdef ANSPWM_SATCNT_EN
      // Clamp held active for 300 frames: counter sticks at 255.
      A = 16'd300;
      for (int f = 0; f < 300; f++) wait_step(300, n);
      chk("sat_max", int'(sat_cnt), 255);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
